// File: rtl/snake_motion_engine_if.sv
// Signal bundle between the snake master/display side and the motion engine.
// The master side drives game state, buttons and the display query; the
// engine (slave side) returns position, food, score and status.
interface snake_motion_engine_if #(
   parameter int X_BITS = 3,
   parameter int Y_BITS = 3
);
   logic [1:0]        STATE_IN;
   logic [3:0]        PUSH_BUTTONS;
   logic [3:0]        SCORE_OUT;
   logic              SUICIDE_OUT;
   logic [X_BITS-1:0] HEAD_X;
   logic [Y_BITS-1:0] HEAD_Y;
   logic [X_BITS-1:0] FOOD_X;
   logic [Y_BITS-1:0] FOOD_Y;
   logic [X_BITS-1:0] QUERY_X;
   logic [Y_BITS-1:0] QUERY_Y;
   logic              QUERY_HIT;

   modport master (
      output STATE_IN, PUSH_BUTTONS, QUERY_X, QUERY_Y,
      input  SCORE_OUT, SUICIDE_OUT, HEAD_X, HEAD_Y, FOOD_X, FOOD_Y, QUERY_HIT
   );

   modport slave (
      input  STATE_IN, PUSH_BUTTONS, QUERY_X, QUERY_Y,
      output SCORE_OUT, SUICIDE_OUT, HEAD_X, HEAD_Y, FOOD_X, FOOD_Y, QUERY_HIT
   );
endinterface

// File: rtl/snake_motion_engine.sv
// Snake motion engine: moves the snake once per game tick on a wrap-around
// grid, steers from the push buttons, grows on food, relocates food with a
// free-running LFSR and answers per-cell occupancy queries.
// Optional build macro WALL_DEATH_EN: leaving the grid on any edge is fatal
// instead of wrapping around.
module snake_motion_engine #(
   parameter int X_BITS      = 3,
   parameter int Y_BITS      = 3,
   parameter int MAX_LEN     = 11,
   parameter int TICK_CYCLES = 12500000,
   parameter int FOOD_X0     = 5,
   parameter int FOOD_Y0     = 4
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   snake_motion_engine_if.slave  bus
);

   localparam int CNT_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int CELL_W = X_BITS + Y_BITS;
   localparam logic [3:0]        SCORE_MAX = 4'd10;
   localparam logic [1:0]        ST_PLAY   = 2'b01;
   localparam logic [X_BITS-1:0] HEAD_X0   = X_BITS'(1 << (X_BITS - 1));
   localparam logic [Y_BITS-1:0] HEAD_Y0   = Y_BITS'(1 << (Y_BITS - 1));

   // Encoding chosen so that XOR with 1 yields the opposite direction.
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

   dir_t              dir, pend_dir, btn_dir;
   logic              btn_valid;
   logic [CNT_W-1:0]  tick_cnt;
   logic [LEN_W-1:0]  len;
   logic [3:0]        score;
   logic              suicide;
   logic [X_BITS-1:0] seg_x [MAX_LEN];
   logic [Y_BITS-1:0] seg_y [MAX_LEN];
   logic [X_BITS-1:0] food_x, next_x, cand_x;
   logic [Y_BITS-1:0] food_y, next_y, cand_y;
   logic              food_pending;
   logic [15:0]       lfsr;
   logic              run, step, fatal, eat, self_hit, cand_hit, query_hit;

   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

   function automatic logic [3:0] sat_score(input logic [3:0] s);
      return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
   endfunction

   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
      return (l >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l + 1'b1;
   endfunction

   assign run    = (bus.STATE_IN == ST_PLAY) && !suicide && (score < SCORE_MAX);
   assign step   = run && (tick_cnt == CNT_W'(TICK_CYCLES - 1));
   assign cand_x = lfsr[X_BITS-1:0];
   assign cand_y = lfsr[CELL_W-1:X_BITS];
   // A step taken while food is being relocated cannot eat.
   assign eat    = step && !fatal && !food_pending && (next_x == food_x) && (next_y == food_y);

   // Decode a single pressed button into a direction; ambiguous input is ignored.
   always_comb begin
      btn_valid = 1'b1;
      btn_dir   = DIR_RIGHT;
      case (bus.PUSH_BUTTONS)
         4'b0001: btn_dir = DIR_UP;
         4'b0010: btn_dir = DIR_DOWN;
         4'b0100: btn_dir = DIR_LEFT;
         4'b1000: btn_dir = DIR_RIGHT;
         default: btn_valid = 1'b0;
      endcase
   end

   // Candidate head position one cell along the pending direction, wrapping modulo the grid.
   always_comb begin
      next_x = seg_x[0];
      next_y = seg_y[0];
      case (pend_dir)
         DIR_UP:    next_y = seg_y[0] - 1'b1;
         DIR_DOWN:  next_y = seg_y[0] + 1'b1;
         DIR_LEFT:  next_x = seg_x[0] - 1'b1;
         DIR_RIGHT: next_x = seg_x[0] + 1'b1;
         default:   next_x = seg_x[0];
      endcase
   end

   // Body occupancy: display query, food candidate, and self-collision (tail excluded, it vacates).
   always_comb begin
      query_hit = 1'b0;
      cand_hit  = 1'b0;
      self_hit  = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len)) begin
            if (seg_x[i] == bus.QUERY_X && seg_y[i] == bus.QUERY_Y) query_hit = 1'b1;
            if (seg_x[i] == cand_x && seg_y[i] == cand_y)           cand_hit  = 1'b1;
         end
         if (i < int'(len) - 1) begin
            if (seg_x[i] == next_x && seg_y[i] == next_y)           self_hit  = 1'b1;
         end
      end
   end

`ifdef WALL_DEATH_EN
   logic wall_hit;

   // Leaving the grid on the edge the snake is heading toward is fatal.
   always_comb begin
      case (pend_dir)
         DIR_UP:    wall_hit = (seg_y[0] == '0);
         DIR_DOWN:  wall_hit = (seg_y[0] == '1);
         DIR_LEFT:  wall_hit = (seg_x[0] == '0);
         DIR_RIGHT: wall_hit = (seg_x[0] == '1);
         default:   wall_hit = 1'b0;
      endcase
   end

   assign fatal = self_hit | wall_hit;
`else
   assign fatal = self_hit;
`endif

   // Game tick divider; advances only while the snake is allowed to move.
   always_ff @(posedge CLOCK) begin
      if (RESET)    tick_cnt <= '0;
      else if (run) tick_cnt <= step ? '0 : tick_cnt + 1'b1;
   end

   // Steering: latch a non-reversing press, commit it as the heading on each step.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         dir      <= DIR_RIGHT;
         pend_dir <= DIR_RIGHT;
      end else begin
         if (btn_valid && btn_dir != opposite(dir)) pend_dir <= btn_dir;
         if (step) dir <= pend_dir;
      end
   end

   // Body shift register, length, score and sticky death flag.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         seg_x[0] <= HEAD_X0;
         seg_y[0] <= HEAD_Y0;
         len      <= LEN_W'(1);
         score    <= '0;
         suicide  <= 1'b0;
      end else if (step) begin
         if (fatal) begin
            suicide <= 1'b1;
         end else begin
            seg_x[0] <= next_x;
            seg_y[0] <= next_y;
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x[i] <= seg_x[i-1];
               seg_y[i] <= seg_y[i-1];
            end
            if (eat) begin
               len   <= sat_len(len);
               score <= sat_score(score);
            end
         end
      end
   end

   // Food: flag a search after eating, then accept the first LFSR cell not on the body.
   // Once the game is won the food stays put so every output holds.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         lfsr         <= 16'hACE1;
         food_x       <= X_BITS'(FOOD_X0);
         food_y       <= Y_BITS'(FOOD_Y0);
         food_pending <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (eat) begin
            food_pending <= 1'b1;
         end else if (food_pending && score < SCORE_MAX && !cand_hit) begin
            food_x       <= cand_x;
            food_y       <= cand_y;
            food_pending <= 1'b0;
         end
      end
   end

   assign bus.SCORE_OUT   = score;
   assign bus.SUICIDE_OUT = suicide;
   assign bus.HEAD_X      = seg_x[0];
   assign bus.HEAD_Y      = seg_y[0];
   assign bus.FOOD_X      = food_x;
   assign bus.FOOD_Y      = food_y;
   assign bus.QUERY_HIT   = query_hit;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Self-checking bench for snake_motion_engine: fixed path table, randomized
// play against a queue-based game model, and hand-built corner sequences.
module tb_snake_motion_engine;

   localparam int TICK = 4;
   localparam int GW   = 8;
   localparam int MAXL = 11;

   logic CLOCK = 1'b0;
   logic RESET;

   snake_motion_engine_if #(.X_BITS(3), .Y_BITS(3)) bus ();

   snake_motion_engine #(
      .X_BITS(3), .Y_BITS(3), .MAX_LEN(MAXL), .TICK_CYCLES(TICK),
      .FOOD_X0(5), .FOOD_Y0(4)
   ) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .bus(bus)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct { int x; int y; } pt_t;
   typedef struct { logic [3:0] btn; int ex; int ey; int qx; int qy; } vec_t;

   // Game model: body as a queue, head first.
   pt_t         m_body[$];
   int          m_score, m_fx, m_fy, m_cnt, m_dir, m_pend, m_steps;
   bit          m_suicide, m_fpend;
   logic [15:0] m_lfsr;

   int n_cmp = 0;
   int n_bad = 0;
   int dxs[4] = '{0, 0, -1, 1};
   int dys[4] = '{-1, 1, 0, 0};

   function automatic bit on_body(int x, int y, int n);
      for (int i = 0; i < n && i < m_body.size(); i++)
         if (m_body[i].x == x && m_body[i].y == y) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int wrapdist(int a, int b);
      int d;
      d = (a > b) ? a - b : b - a;
      return (d < GW - d) ? d : GW - d;
   endfunction

   task automatic model_reset();
      pt_t p;
      m_body.delete();
      p.x = 4; p.y = 4;
      m_body.push_back(p);
      m_score = 0; m_suicide = 1'b0; m_fx = 5; m_fy = 4; m_fpend = 1'b0;
      m_cnt = 0; m_dir = 3; m_pend = 3; m_lfsr = 16'hACE1;
   endtask

   task automatic model_clock();
      bit run, step, fatal, eat, reloc;
      int cx, cy, rx, ry, nx, ny, bd, old_dir, old_pend;
      pt_t p;
      if (RESET) begin
         model_reset();
         return;
      end
      old_dir  = m_dir;
      old_pend = m_pend;
      run  = (bus.STATE_IN == 2'b01) && !m_suicide && (m_score < 10);
      step = run && (m_cnt == TICK - 1);
      cx = int'(m_lfsr[2:0]);
      cy = int'(m_lfsr[5:3]);
      reloc = m_fpend && (m_score < 10) && !on_body(cx, cy, m_body.size());
      if (step) begin
         rx = m_body[0].x + dxs[old_pend];
         ry = m_body[0].y + dys[old_pend];
         nx = (rx + GW) % GW;
         ny = (ry + GW) % GW;
         fatal = on_body(nx, ny, m_body.size() - 1);
`ifdef WALL_DEATH_EN
         if (rx < 0 || rx >= GW || ry < 0 || ry >= GW) fatal = 1'b1;
`endif
         if (fatal) begin
            m_suicide = 1'b1;
         end else begin
            eat = !m_fpend && nx == m_fx && ny == m_fy;
            p.x = nx; p.y = ny;
            m_body.push_front(p);
            if (!eat || m_body.size() > MAXL) void'(m_body.pop_back());
            if (eat) begin
               if (m_score < 10) m_score++;
               m_fpend = 1'b1;
            end
         end
         m_dir = old_pend;
         m_steps++;
      end
      if (reloc) begin
         m_fx = cx; m_fy = cy; m_fpend = 1'b0;
      end
      if (run) m_cnt = step ? 0 : m_cnt + 1;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      case (bus.PUSH_BUTTONS)
         4'b0001: bd = 0;
         4'b0010: bd = 1;
         4'b0100: bd = 2;
         4'b1000: bd = 3;
         default: bd = -1;
      endcase
      if (bd >= 0 && bd != (old_dir ^ 1)) m_pend = bd;
   endtask

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_timeout(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired, got no progress, expected completion", name);
   endtask

   task automatic compare_all();
      chk("head_x",    int'(bus.HEAD_X),      m_body[0].x);
      chk("head_y",    int'(bus.HEAD_Y),      m_body[0].y);
      chk("score",     int'(bus.SCORE_OUT),   m_score);
      chk("suicide",   int'(bus.SUICIDE_OUT), int'(m_suicide));
      chk("food_x",    int'(bus.FOOD_X),      m_fx);
      chk("food_y",    int'(bus.FOOD_Y),      m_fy);
      chk("query_hit", int'(bus.QUERY_HIT),
          int'(on_body(int'(bus.QUERY_X), int'(bus.QUERY_Y), m_body.size())));
   endtask

   task automatic cycle();
      @(posedge CLOCK);
      model_clock();
      #1;
      compare_all();
   endtask

   // Steer toward the food, preferring moves that do not hit the body.
   function automatic logic [3:0] greedy_btn();
      int best, bestd, rx, ry, nx, ny, d2;
      bit safe;
      best = 3; bestd = 100000;
      for (int d = 0; d < 4; d++) begin
         if (d == (m_dir ^ 1)) continue;
         rx = m_body[0].x + dxs[d];
         ry = m_body[0].y + dys[d];
         nx = (rx + GW) % GW;
         ny = (ry + GW) % GW;
         safe = !on_body(nx, ny, m_body.size() - 1);
`ifdef WALL_DEATH_EN
         if (rx < 0 || rx >= GW || ry < 0 || ry >= GW) safe = 1'b0;
`endif
         d2 = wrapdist(nx, m_fx) + wrapdist(ny, m_fy) + (safe ? 0 : 1000);
         if (d2 < bestd) begin
            bestd = d2;
            best  = d;
         end
      end
      return 4'(1 << best);
   endfunction

   task automatic pulse_reset();
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
   endtask

   task automatic grow_until(int tlen, int tscore, int budget, output bit ok);
      ok = 1'b0;
      bus.STATE_IN = 2'b01;
      while (budget > 0) begin
         if (m_suicide) pulse_reset();
         if (m_body.size() >= tlen && m_score >= tscore) begin
            ok = 1'b1;
            break;
         end
         bus.PUSH_BUTTONS = greedy_btn();
         cycle();
         budget--;
      end
   endtask

   task automatic hold_steps(int n, logic [3:0] btn, string tag);
      int start, budget;
      start = m_steps;
      budget = n * TICK * 2 + 10;
      bus.PUSH_BUTTONS = btn;
      while (m_steps < start + n && !m_suicide && budget > 0) begin
         cycle();
         budget--;
      end
      if (m_steps < start + n && !m_suicide) fail_timeout(tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   n_vec, hx, hy, D, P, r;
      bit   ok;

      // Fixed path that never revisits a cell, so head motion is food-independent.
      vecs[0] = '{4'h0, 5, 4, 4, 4};
      vecs[1] = '{4'h4, 6, 4, 5, 4};
      vecs[2] = '{4'h5, 7, 4, 6, 4};
`ifdef WALL_DEATH_EN
      vecs[3] = '{4'h8, 7, 4, 6, 4};
      n_vec   = 4;
`else
      vecs[3] = '{4'h8, 0, 4, 7, 4};
      n_vec   = 10;
`endif
      vecs[4] = '{4'h1, 0, 3, 0, 4};
      vecs[5] = '{4'h0, 0, 2, 0, 3};
      vecs[6] = '{4'h2, 0, 1, 0, 2};
      vecs[7] = '{4'h4, 7, 1, 0, 1};
      vecs[8] = '{4'h2, 7, 2, 7, 1};
      vecs[9] = '{4'hF, 7, 3, 7, 2};

      model_reset();
      m_steps = 0;
      RESET = 1'b1;
      bus.STATE_IN = 2'b00;
      bus.PUSH_BUTTONS = 4'h0;
      bus.QUERY_X = 3'd0;
      bus.QUERY_Y = 3'd0;
      cycle();
      cycle();
      RESET = 1'b0;
      cycle();

      chk("rst_head_x", int'(bus.HEAD_X), 4);
      chk("rst_head_y", int'(bus.HEAD_Y), 4);
      chk("rst_score", int'(bus.SCORE_OUT), 0);
      chk("rst_suicide", int'(bus.SUICIDE_OUT), 0);
      chk("rst_food_x", int'(bus.FOOD_X), 5);
      chk("rst_food_y", int'(bus.FOOD_Y), 4);

      bus.STATE_IN = 2'b01;
      for (int v = 0; v < n_vec; v++) begin
         bus.PUSH_BUTTONS = vecs[v].btn;
         repeat (TICK) cycle();
         chk("vec_head_x", int'(bus.HEAD_X), vecs[v].ex);
         chk("vec_head_y", int'(bus.HEAD_Y), vecs[v].ey);
         if (v == 0) chk("first_eat_score", int'(bus.SCORE_OUT), 1);
         bus.QUERY_X = 3'(vecs[v].qx);
         bus.QUERY_Y = 3'(vecs[v].qy);
         #1 chk("vec_query_prev", int'(bus.QUERY_HIT), 1);
         bus.QUERY_X = 3'(vecs[v].ex);
         bus.QUERY_Y = 3'(vecs[v].ey);
         #1 chk("vec_query_head", int'(bus.QUERY_HIT), 1);
         bus.QUERY_X = 3'd2;
         bus.QUERY_Y = 3'd6;
         #1 chk("vec_query_empty", int'(bus.QUERY_HIT), 0);
      end
`ifdef WALL_DEATH_EN
      chk("wall_suicide", int'(bus.SUICIDE_OUT), 1);
`endif

      // Randomized play against the model.
      for (int c = 0; c < 2000; c++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      bus.PUSH_BUTTONS = 4'(1 << r);
         else if (r < 8) bus.PUSH_BUTTONS = 4'h0;
         else            bus.PUSH_BUTTONS = 4'($urandom_range(0, 15));
         bus.STATE_IN = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         bus.QUERY_X  = 3'($urandom_range(0, 7));
         bus.QUERY_Y  = 3'($urandom_range(0, 7));
         RESET        = ($urandom_range(0, 149) == 0);
         cycle();
      end
      RESET = 1'b0;

      // Grow to five segments, run straight, then turn back into the body.
      pulse_reset();
      grow_until(5, 0, 6000, ok);
      if (!ok) fail_timeout("grow_to_5");
      D = m_pend;
      P = (D < 2) ? 3 : 0;
      hold_steps(4, 4'h0, "straight");
      hold_steps(1, 4'(1 << P), "turn_1");
      hold_steps(1, 4'(1 << (D ^ 1)), "turn_2");
      hold_steps(1, 4'(1 << (P ^ 1)), "turn_3");
      chk("collision_suicide", int'(bus.SUICIDE_OUT), 1);
      hx = m_body[0].x;
      hy = m_body[0].y;
      repeat (20 * TICK) begin
         bus.PUSH_BUTTONS = 4'($urandom_range(0, 15));
         cycle();
      end
      chk("frozen_head_x", int'(bus.HEAD_X), hx);
      chk("frozen_head_y", int'(bus.HEAD_Y), hy);
      chk("frozen_suicide", int'(bus.SUICIDE_OUT), 1);

      // Win condition: score 10 stops all motion.
      pulse_reset();
      grow_until(1, 10, 40000, ok);
      if (!ok) fail_timeout("reach_score_10");
      chk("win_score", int'(bus.SCORE_OUT), 10);
      hx = m_body[0].x;
      hy = m_body[0].y;
      repeat (3 * TICK) begin
         bus.PUSH_BUTTONS = 4'(1 << $urandom_range(0, 3));
         cycle();
      end
      chk("win_head_x", int'(bus.HEAD_X), hx);
      chk("win_head_y", int'(bus.HEAD_Y), hy);
      chk("win_score_hold", int'(bus.SCORE_OUT), 10);

      // Idle state: no movement at all.
      bus.STATE_IN = 2'b00;
      pulse_reset();
      repeat (3 * TICK) begin
         bus.PUSH_BUTTONS = 4'(1 << $urandom_range(0, 3));
         cycle();
      end
      chk("idle_head_x", int'(bus.HEAD_X), 4);
      chk("idle_head_y", int'(bus.HEAD_Y), 4);

      // Reset in the middle of play.
      bus.STATE_IN = 2'b01;
      repeat (9) begin
         bus.PUSH_BUTTONS = 4'(1 << $urandom_range(0, 3));
         cycle();
      end
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
      chk("midrst_head_x", int'(bus.HEAD_X), 4);
      chk("midrst_head_y", int'(bus.HEAD_Y), 4);
      chk("midrst_score", int'(bus.SCORE_OUT), 0);
      chk("midrst_suicide", int'(bus.SUICIDE_OUT), 0);
      chk("midrst_food_x", int'(bus.FOOD_X), 5);
      chk("midrst_food_y", int'(bus.FOOD_Y), 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
